// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and the default bit timing used by
// both the transmitter and receiver.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        s_idle         = 3'd0,
        s_tx_start_bit = 3'd1,
        s_tx_data_bits = 3'd2,
        s_tx_stop_bit  = 3'd3,
        s_cleanup      = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB-first, one stop bit.
// All outputs come straight from flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned clks_per_bit = CLKS_PER_BIT,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       i_clock,
    input  logic       i_rst_n,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_tx_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(clks_per_bit - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             serial_q, serial_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= s_idle;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // serial_d is the value for the *next* cycle, so bit boundaries preload the next bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        serial_d = serial_q;
        active_d = active_q;
        done_d   = 1'b0;

        case (state_q)
            s_idle: begin
                serial_d = 1'b1;
                cnt_d    = '0;
                idx_d    = '0;
                if (i_tx_dv) begin
                    data_d   = i_tx_byte;
                    active_d = 1'b1;
                    serial_d = 1'b0;
                    state_d  = s_tx_start_bit;
                end
            end

            s_tx_start_bit: begin
                serial_d = 1'b0;
                if (cnt_q < LAST_CNT) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = data_q[0];
                    state_d  = s_tx_data_bits;
                end
            end

            s_tx_data_bits: begin
                serial_d = data_q[idx_q];
                if (cnt_q < LAST_CNT) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (idx_q < 3'd7) begin
                        idx_d    = idx_q + 3'd1;
                        serial_d = data_q[idx_q + 3'd1];
                    end else begin
                        idx_d    = '0;
                        serial_d = 1'b1;
                        state_d  = s_tx_stop_bit;
                    end
                end
            end

            s_tx_stop_bit: begin
                serial_d = 1'b1;
                if (cnt_q < LAST_CNT) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = s_cleanup;
                end
            end

            s_cleanup: begin
                serial_d = 1'b1;
                state_d  = s_idle;
            end

            default: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
                idx_d    = '0;
                state_d  = s_idle;
            end
        endcase
    end

    assign o_tx_serial = serial_q;
    assign o_tx_active = active_q;
    assign o_tx_done   = done_q;

endmodule
